// File: rtl/accumulator_pkg.sv
// Shared encodings for the N-operand bus accumulator processor:
// bus op codes, one-hot FSM states, reduction modes and a debug decode.
package accumulator_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_FETCH = 2'b01,
    OP_SEND  = 2'b10
  } op_e;

  typedef enum logic [4:0] {
    ST_REQ_F   = 5'b00001,
    ST_FETCH   = 5'b00010,
    ST_COMPUTE = 5'b00100,
    ST_REQ_S   = 5'b01000,
    ST_SEND    = 5'b10000
  } state_e;

  typedef enum logic [1:0] {
    MODE_ADD    = 2'b00,
    MODE_SATADD = 2'b01,
    MODE_MAX    = 2'b10,
    MODE_MIN    = 2'b11
  } mode_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic string state_string(input state_e s);
    case (s)
      ST_REQ_F:   return "REQ_F";
      ST_FETCH:   return "FETCH";
      ST_COMPUTE: return "COMPUTE";
      ST_REQ_S:   return "REQ_S";
      ST_SEND:    return "SEND";
      default:    return "ILLEGAL";
    endcase
  endfunction

endpackage

// File: rtl/acc_lfsr.sv
// 16-bit Galois LFSR (right-shifting) that supplies the pseudo-random
// part of the compute delay; advances one step per enabled clock.
module acc_lfsr
  import accumulator_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED;
    end else if (step) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/accumulator_processor_n.sv
// Bus accumulator: fetches NUM_OPS operands, reduces them with the mode
// latched at the job's first grant, waits a pseudo-random delay, sends.
module accumulator_processor_n
  import accumulator_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          NUM_OPS    = 2,
  parameter int          DELAY_MIN  = 1000,
  parameter logic [15:0] DELAY_MASK = 16'h1FFF,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              grant,
  input  logic              signal,
  input  logic [DATA_W-1:0] read,
  output logic              req,
  output logic [1:0]        op,
  output logic [DATA_W-1:0] write,
  output logic              write_oe,
  output logic [4:0]        state,
  output logic [3:0]        op_idx,
  output logic              ovf,
  output logic [15:0]       jobs_done
);

  localparam logic [3:0]  LAST_IDX    = 4'(NUM_OPS - 1);
  localparam logic [31:0] DELAY_MIN_W = 32'(DELAY_MIN);

  state_e            cur;
  mode_e             job_mode;
  logic [DATA_W-1:0] acc;
  logic [31:0]       delay_cnt;
  logic [15:0]       lfsr_val;
  logic              lfsr_step;
  logic [31:0]       delay_load;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] acc_next;
  logic              ovf_next;

  assign state      = cur;
  assign lfsr_step  = (cur == ST_FETCH) && signal && (op_idx == LAST_IDX);
  assign delay_load = DELAY_MIN_W + {16'h0000, lfsr_val & DELAY_MASK};

  acc_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  // Reduction step; the carry out of the widened sum flags wrap/clamp.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, read};
    acc_next = acc;
    ovf_next = ovf;
    if (op_idx == 4'd0) begin
      acc_next = read;
    end else begin
      case (job_mode)
        MODE_ADD: begin
          acc_next = sum[DATA_W-1:0];
          ovf_next = ovf | sum[DATA_W];
        end
        MODE_SATADD: begin
          acc_next = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
          ovf_next = ovf | sum[DATA_W];
        end
        MODE_MAX: acc_next = (read > acc) ? read : acc;
        MODE_MIN: acc_next = (read < acc) ? read : acc;
        default:  acc_next = acc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= ST_REQ_F;
      op_idx    <= 4'd0;
      acc       <= {DATA_W{1'b0}};
      ovf       <= 1'b0;
      jobs_done <= 16'd0;
      delay_cnt <= 32'd0;
      job_mode  <= MODE_ADD;
    end else begin
      case (cur)
        ST_REQ_F: begin
          if (grant && !signal) begin
            cur <= ST_FETCH;
            if (op_idx == 4'd0) begin
              job_mode <= mode_e'(mode);
              ovf      <= 1'b0;
            end
          end
        end
        ST_FETCH: begin
          if (signal) begin
            acc <= acc_next;
            ovf <= ovf_next;
            if (op_idx == LAST_IDX) begin
              op_idx    <= 4'd0;
              delay_cnt <= delay_load;
              cur       <= ST_COMPUTE;
            end else begin
              op_idx <= op_idx + 4'd1;
              cur    <= ST_REQ_F;
            end
          end
        end
        // A loaded delay of D yields D+1 cycles in COMPUTE.
        ST_COMPUTE: begin
          if (delay_cnt == 32'd0) begin
            cur <= ST_REQ_S;
          end else begin
            delay_cnt <= delay_cnt - 32'd1;
          end
        end
        ST_REQ_S: begin
          if (grant && !signal) begin
            cur <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (signal) begin
            jobs_done <= jobs_done + 16'd1;
            cur       <= ST_REQ_F;
          end
        end
        default: cur <= ST_REQ_F;
      endcase
    end
  end

  always_comb begin
    req      = 1'b1;
    op       = OP_NOP;
    write    = {DATA_W{1'b0}};
    write_oe = 1'b0;
    case (cur)
      ST_COMPUTE: req = 1'b0;
      ST_FETCH:   op  = OP_FETCH;
      ST_SEND: begin
        op       = OP_SEND;
        write    = acc;
        write_oe = 1'b1;
      end
      default: req = 1'b1;
    endcase
  end

endmodule
